// File: rtl/fir_output_stage_if.sv
// Capture input, status and output handshake bundle for the FIR output stage.
// slave is the stage's own view; master is the producer/sink environment.
interface fir_output_stage_if #(
    parameter int ACC_W  = 36,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 2
);
    logic                    capture_en;
    logic signed [ACC_W-1:0] acc_in;
    logic                    clear_flags;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sat_flag;
    logic                    overflow;
    logic [ADDR_W:0]         fifo_level;

    modport slave (
        input  capture_en, acc_in, clear_flags, out_ready,
        output out_data, out_valid, sat_flag, overflow, fifo_level
    );

    modport master (
        output capture_en, acc_in, clear_flags, out_ready,
        input  out_data, out_valid, sat_flag, overflow, fifo_level
    );
endinterface

// File: rtl/fir_output_stage.sv
// Rounds/saturates the MAC accumulator on capture_en and queues it for a valid/ready sink.
// Capture to out_valid takes 2 edges; a push into a full FIFO with no pop is dropped and flags overflow.
module fir_output_stage #(
    parameter int ACC_W  = 36,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    fir_output_stage_if.slave   bus
);
    // Extra sign bit keeps the rounding add from wrapping at the top of the accumulator range.
    localparam logic signed [ACC_W:0] ROUND_C = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic                    stage_valid_q, stage_valid_d;
    logic signed [OUT_W-1:0] stage_data_q, stage_data_d;
    logic                    sat_flag_q, sat_flag_d;
    logic                    overflow_q, overflow_d;
    logic [OUT_W-1:0]        mem_q [DEPTH];
    logic [OUT_W-1:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]         count_q, count_d;

    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [ACC_W:0]   acc_rnd;
    logic                    sat_hi, sat_lo;
    logic                    not_empty, full, pop, push, drop;

    always_comb begin
        acc_ext = {bus.acc_in[ACC_W-1], bus.acc_in};
        acc_sum = acc_ext + ROUND_C;
        acc_rnd = acc_sum >>> SHIFT;
        sat_hi  = acc_rnd > SAT_MAX;
        sat_lo  = acc_rnd < SAT_MIN;

        stage_valid_d = bus.capture_en;
        stage_data_d  = stage_data_q;
        if (bus.capture_en) begin
            if (sat_hi)      stage_data_d = SAT_MAX[OUT_W-1:0];
            else if (sat_lo) stage_data_d = SAT_MIN[OUT_W-1:0];
            else             stage_data_d = acc_rnd[OUT_W-1:0];
        end
    end

    // A full FIFO still accepts the staged sample when the head leaves at the same edge.
    always_comb begin
        not_empty = count_q != '0;
        full      = count_q == (ADDR_W + 1)'(DEPTH);
        pop       = not_empty && bus.out_ready;
        push      = stage_valid_q && (!full || pop);
        drop      = stage_valid_q && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = stage_data_q;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        count_d = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);

        sat_flag_d = (bus.capture_en && (sat_hi || sat_lo)) || (sat_flag_q && !bus.clear_flags);
        overflow_d = drop || (overflow_q && !bus.clear_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            sat_flag_q    <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            sat_flag_q    <= sat_flag_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

    assign bus.out_data   = mem_q[rd_ptr_q];
    assign bus.out_valid  = not_empty;
    assign bus.sat_flag   = sat_flag_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = count_q;
endmodule

// File: tb/tb_fir_output_stage.sv
// Scoreboard bench for fir_output_stage: expected samples queue at capture, compare at each handshake.
module tb_fir_output_stage;
    logic clk = 1'b0;
    logic reset;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    logic signed [15:0] exp_q [$];

    fir_output_stage_if #(.ACC_W(36), .OUT_W(16), .ADDR_W(2)) bus ();

    fir_output_stage #(
        .ACC_W(36), .OUT_W(16), .SHIFT(15), .DEPTH(4), .ADDR_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one edge; a handshake visible before the edge consumes the scoreboard head.
    task automatic tick();
        logic signed [15:0] e;
        if (bus.out_valid && bus.out_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_unexpected: got sample %0d, required no output", $signed(bus.out_data));
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e)
                    $display("FAIL scoreboard_data: got %0d required %0d", $signed(bus.out_data), e);
                else
                    pass_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic signed [35:0] acc, input logic signed [15:0] exp, input bit keep);
        bus.capture_en = 1'b1;
        bus.acc_in     = acc;
        if (keep) exp_q.push_back(exp);
        tick();
        bus.capture_en = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.capture_en  = 1'b0;
        bus.acc_in      = '0;
        bus.clear_flags = 1'b0;
        bus.out_ready   = 1'b0;
        #12;
        total_cnt++;
        if ({bus.out_valid, bus.sat_flag, bus.overflow, bus.fifo_level, bus.out_data} !== 22'd0)
            $display("FAIL reset_outputs: got valid=%0b sat=%0b ovf=%0b lvl=%0d data=%0d, required all 0",
                     bus.out_valid, bus.sat_flag, bus.overflow, bus.fifo_level, bus.out_data);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b0;
        capture(36'sd3276800, 16'sd100, 1'b1);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL basic_latency: got out_valid=%0b after capture edge, required 0", bus.out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd100 || bus.fifo_level !== 3'd1)
            $display("FAIL basic_push: got valid=%0b data=%0d lvl=%0d, required 1/100/1",
                     bus.out_valid, $signed(bus.out_data), bus.fifo_level);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0)
            $display("FAIL basic_pop: got valid=%0b lvl=%0d, required 0/0", bus.out_valid, bus.fifo_level);
        else pass_cnt++;
    endtask

    task automatic test_rounding();
        bus.out_ready = 1'b1;
        capture(36'sd16384,   16'sd1,  1'b1);
        capture(36'sd16383,   16'sd0,  1'b1);
        capture(-36'sd16384,  16'sd0,  1'b1);
        capture(-36'sd16385, -16'sd1,  1'b1);
        for (int i = 0; i < 3; i++) tick();
        total_cnt++;
        if (bus.sat_flag !== 1'b0) $display("FAIL rounding_sat: got sat_flag=%0b required 0", bus.sat_flag);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL rounding_drain: got %0d samples outstanding, required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b1;
        capture(36'sh80000000, 16'sd32767, 1'b1);
        total_cnt++;
        if (bus.sat_flag !== 1'b1) $display("FAIL sat_set: got sat_flag=%0b required 1", bus.sat_flag);
        else pass_cnt++;
        capture(-36'sh80000000, -16'sd32768, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        total_cnt++;
        if (bus.sat_flag !== 1'b0) $display("FAIL sat_clear: got sat_flag=%0b required 0", bus.sat_flag);
        else pass_cnt++;
        bus.clear_flags = 1'b1;
        capture(36'sh7FFFFFFFF, 16'sd32767, 1'b1);
        bus.clear_flags = 1'b0;
        total_cnt++;
        if (bus.sat_flag !== 1'b1) $display("FAIL sat_set_wins: got sat_flag=%0b required 1", bus.sat_flag);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        total_cnt++;
        if (exp_q.size() != 0 || bus.sat_flag !== 1'b0)
            $display("FAIL sat_drain: got %0d outstanding sat=%0b, required 0/0", exp_q.size(), bus.sat_flag);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) capture(36'(k * 32768), 16'(k), k <= 4);
        tick();
        tick();
        total_cnt++;
        if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b1 || bus.out_data !== 16'sd1)
            $display("FAIL overflow_full: got lvl=%0d ovf=%0b head=%0d, required 4/1/1",
                     bus.fifo_level, bus.overflow, $signed(bus.out_data));
        else pass_cnt++;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.fifo_level !== 3'd0 || bus.out_valid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL overflow_drain: got lvl=%0d valid=%0b outstanding=%0d, required 0/0/0",
                     bus.fifo_level, bus.out_valid, exp_q.size());
        else pass_cnt++;
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        total_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL overflow_clear: got overflow=%0b required 0", bus.overflow);
        else pass_cnt++;
    endtask

    task automatic test_full_push_pop();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) capture(36'(k * 32768), 16'(k), 1'b1);
        tick();
        tick();
        total_cnt++;
        if (bus.fifo_level !== 3'd4) $display("FAIL fullpp_fill: got lvl=%0d required 4", bus.fifo_level);
        else pass_cnt++;
        capture(36'(9 * 32768), 16'sd9, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.fifo_level !== 3'd4 || bus.overflow !== 1'b0)
            $display("FAIL fullpp_same_edge: got lvl=%0d ovf=%0b, required 4/0", bus.fifo_level, bus.overflow);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.fifo_level !== 3'd0 || exp_q.size() != 0)
            $display("FAIL fullpp_drain: got lvl=%0d outstanding=%0d, required 0/0", bus.fifo_level, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) capture(36'(k * 32768), 16'(k), 1'b1);
        tick();
        tick();
        total_cnt++;
        if (bus.fifo_level !== 3'd3) $display("FAIL areset_fill: got lvl=%0d required 3", bus.fifo_level);
        else pass_cnt++;
        capture(36'(7 * 32768), 16'sd7, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        total_cnt++;
        if ({bus.out_valid, bus.sat_flag, bus.overflow, bus.fifo_level, bus.out_data} !== 22'd0)
            $display("FAIL areset_immediate: got valid=%0b sat=%0b ovf=%0b lvl=%0d data=%0d, required all 0",
                     bus.out_valid, bus.sat_flag, bus.overflow, bus.fifo_level, bus.out_data);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.fifo_level !== 3'd0)
                $display("FAIL areset_no_push: got valid=%0b lvl=%0d at cycle %0d, required 0/0",
                         bus.out_valid, bus.fifo_level, i);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
